// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: parity modes, the
// FSM state encoding, and helpers that both directions must agree on.
package uart_pkg;

  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD  = 1;
  localparam int UART_CHECK_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  // Bit period in system clocks; rx and tx both call this so their timing matches.
  function automatic int uart_div(input int clk, input int baud);
    return clk / baud;
  endfunction

  // Unused upper data bits are zero, so they do not disturb the XOR.
  function automatic logic uart_parity_ok(input logic [7:0] data, input logic par, input int mode);
    logic ok;
    case (mode)
      UART_CHECK_ODD:  ok = (^{data, par}) == 1'b1;
      UART_CHECK_EVEN: ok = (^{data, par}) == 1'b0;
      default:         ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// User-side receive channel: the received word plus its valid/error pulses.
interface uart_rx_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] o_user_rx_data;
  logic          o_user_rx_valid;
  logic          o_user_rx_err;

  modport master (output o_user_rx_data, output o_user_rx_valid, output o_user_rx_err);
  modport slave  (input  o_user_rx_data, input  o_user_rx_valid, input  o_user_rx_err);
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs (rx line, CTS).
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic sync_r;

  // Two register stages to settle metastability before the value is used.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples the line, validates start, samples data mid-bit,
// checks optional parity and stop bits, and pulses valid or err per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_uart_rx,
  uart_rx_if.master user
);
  localparam int DIV  = uart_div(P_SYSTEM_CLK, P_UART_BUADRATE);
  localparam int HALF = DIV / 2;
  localparam int N    = P_UART_DATA_WIDTH;
  localparam int F    = N + ((P_UART_CHECK != UART_CHECK_NONE) ? 1 : 0) + P_UART_STOP_WIDTH;
  localparam int CW   = $clog2(DIV);
  localparam int BW   = $clog2(F + 1);

  logic          rx_sync_s;
  logic          rx_prev_r;
  logic          fall_s;
  uart_state_e   state_r;
  logic [CW-1:0] baud_cnt_r;
  logic [BW-1:0] bit_cnt_r;
  logic [BW-1:0] bit_inc_s;
  logic          baud_last_s;
  logic [N-1:0]  shift_r;
  logic          frame_err_r;
  logic [N-1:0]  data_r;
  logic          valid_r;
  logic          err_r;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (i_uart_rx),
    .q     (rx_sync_s)
  );

  assign fall_s      = rx_prev_r & ~rx_sync_s;
  assign baud_last_s = (baud_cnt_r == CW'(DIV - 1));
  // Saturating so the count can never wrap inside a frame.
  assign bit_inc_s   = (bit_cnt_r == BW'(F)) ? bit_cnt_r : bit_cnt_r + BW'(1);

  // Receive FSM with baud/bit counters, shift register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_prev_r   <= 1'b1;
      state_r     <= ST_IDLE;
      baud_cnt_r  <= '0;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      frame_err_r <= 1'b0;
      data_r      <= '0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      rx_prev_r <= rx_sync_s;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            state_r     <= ST_START;
            baud_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            frame_err_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (baud_cnt_r == CW'(HALF - 1)) begin
            baud_cnt_r <= '0;
            // A line already back high at mid-start was a glitch.
            if (!rx_sync_s) begin
              state_r <= ST_DATA;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last_s) begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= bit_inc_s;
            shift_r    <= {rx_sync_s, shift_r[N-1:1]};
            if (bit_inc_s == BW'(N)) begin
              state_r <= (P_UART_CHECK != UART_CHECK_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        ST_PARITY: begin
          if (baud_last_s) begin
            baud_cnt_r  <= '0;
            bit_cnt_r   <= bit_inc_s;
            frame_err_r <= frame_err_r | ~uart_parity_ok(8'(shift_r), rx_sync_s, P_UART_CHECK);
            state_r     <= ST_STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last_s) begin
            baud_cnt_r  <= '0;
            bit_cnt_r   <= bit_inc_s;
            frame_err_r <= frame_err_r | ~rx_sync_s;
            // Leaving at mid-stop lets a back-to-back start edge be caught.
            if (bit_inc_s == BW'(F)) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_STOP;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          data_r  <= shift_r;
          state_r <= ST_IDLE;
          if (frame_err_r) begin
            err_r <= 1'b1;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign user.o_user_rx_data  = data_r;
  assign user.o_user_rx_valid = valid_r;
  assign user.o_user_rx_err   = err_r;
endmodule
